rle_decoder: RTL and testbench

RLE_DECODER -- requirements
Module: rle_decoder

---
 rtl/rle_decoder.sv | 202 ++++++++++++++++++++
 tb/tb_rle_decoder.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/rle_decoder.sv
// Run-length decoder: reads (count,value) byte pairs from a dpsram and writes the expanded byte stream back through the same port.
// Optional output bound selected by macro RLD_BOUND_CHECK_EN (adds message_limit / overflow).
module rle_decoder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [31:0]       rle_size,
    input  logic [31:0]       message_addr,
`ifdef RLD_BOUND_CHECK_EN
    input  logic [31:0]       message_limit,
    output logic              overflow,
`endif
    output logic [31:0]       message_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out,
    output logic [2:0]        state_dbg
);

    // start is taken only in IDLE; done rises in FINISH and holds until the next accepted start.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        RD_REQ = 3'd1,
        RD_LAT = 3'd2,
        EXPAND = 3'd3,
        WRITE  = 3'd4,
        FLUSH  = 3'd5,
        FINISH = 3'd6
    } state_t;

    state_t            state, state_next, resume, after_pair;
    logic [ADDR_W-1:0] rd_addr, wr_addr;
    logic [30:0]       pairs_left;
    logic [31:0]       word_r;
    logic              pair_sel;
    logic [7:0]        cnt;
    logic [31:0]       out_buf;
    logic [1:0]        byte_idx;
    logic [31:0]       msg_size;
    logic              done_r;
    logic [7:0]        cur_val;
    logic              has_byte, keep, pair_last, buf_full;
`ifdef RLD_BOUND_CHECK_EN
    logic [31:0]       limit_r;
    logic              ovf_r;
`endif

    logic unused_bits;
    assign unused_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W], rle_size[0]};

    assign port_A_clk   = clk;
    assign message_size = msg_size;
    assign done         = done_r;
    assign state_dbg    = state;
`ifdef RLD_BOUND_CHECK_EN
    assign overflow     = ovf_r;
`endif

    assign cur_val   = pair_sel ? word_r[31:24] : word_r[15:8];
    assign has_byte  = (cnt != 8'd0);
    assign pair_last = (cnt <= 8'd1);
`ifdef RLD_BOUND_CHECK_EN
    assign keep      = has_byte && (msg_size != limit_r);
`else
    assign keep      = has_byte;
`endif
    assign buf_full  = keep && (byte_idx == 2'd3);

    // Where EXPAND goes once the current byte is handled (also the return point after a WRITE).
    always_comb begin
        after_pair = EXPAND;
        if (pair_last) begin
            if (pairs_left == 31'd1)
                after_pair = FLUSH;
            else if (pair_sel)
                after_pair = RD_REQ;
            else
                after_pair = EXPAND;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RD_REQ;
            RD_REQ:  state_next = (pairs_left == 31'd0) ? FLUSH : RD_LAT;
            RD_LAT:  state_next = EXPAND;
            EXPAND:  state_next = buf_full ? WRITE : after_pair;
            WRITE:   state_next = resume;
            FLUSH:   state_next = FINISH;
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Port A is idle (all zero) outside read-request and write cycles.
    always_comb begin
        port_A_we      = 1'b0;
        port_A_addr    = '0;
        port_A_data_in = '0;
        case (state)
            RD_REQ: if (pairs_left != 31'd0) port_A_addr = rd_addr;
            WRITE: begin
                port_A_we      = 1'b1;
                port_A_addr    = wr_addr;
                port_A_data_in = out_buf;
            end
            FLUSH: if (byte_idx != 2'd0) begin
                port_A_we      = 1'b1;
                port_A_addr    = wr_addr;
                port_A_data_in = out_buf;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state      <= IDLE;
            resume     <= IDLE;
            rd_addr    <= '0;
            wr_addr    <= '0;
            pairs_left <= '0;
            word_r     <= '0;
            pair_sel   <= 1'b0;
            cnt        <= '0;
            out_buf    <= '0;
            byte_idx   <= '0;
            msg_size   <= '0;
            done_r     <= 1'b0;
`ifdef RLD_BOUND_CHECK_EN
            limit_r    <= '0;
            ovf_r      <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: if (start) begin
                    rd_addr    <= rle_addr[ADDR_W-1:0];
                    wr_addr    <= message_addr[ADDR_W-1:0];
                    pairs_left <= rle_size[31:1];
                    pair_sel   <= 1'b0;
                    cnt        <= '0;
                    out_buf    <= '0;
                    byte_idx   <= '0;
                    msg_size   <= '0;
                    done_r     <= 1'b0;
`ifdef RLD_BOUND_CHECK_EN
                    limit_r    <= message_limit;
                    ovf_r      <= 1'b0;
`endif
                end
                RD_LAT: begin
                    word_r   <= port_A_data_out;
                    pair_sel <= 1'b0;
                    cnt      <= port_A_data_out[7:0];
                end
                EXPAND: begin
                    if (keep) begin
                        out_buf[{byte_idx, 3'b000} +: 8] <= cur_val;
                        byte_idx <= byte_idx + 2'd1;
                        msg_size <= msg_size + 32'd1;
                    end
`ifdef RLD_BOUND_CHECK_EN
                    if (has_byte && !keep) ovf_r <= 1'b1;
`endif
                    // A pair finishes on its last byte (or at once if its count is zero).
                    if (pair_last) begin
                        pairs_left <= pairs_left - 31'd1;
                        if (!pair_sel) begin
                            pair_sel <= 1'b1;
                            cnt      <= word_r[23:16];
                        end else begin
                            rd_addr  <= rd_addr + ADDR_W'(4);
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                    if (buf_full) resume <= after_pair;
                end
                WRITE: begin
                    wr_addr <= wr_addr + ADDR_W'(4);
                    out_buf <= '0;
                end
                FLUSH: begin
                    if (byte_idx != 2'd0) wr_addr <= wr_addr + ADDR_W'(4);
                    out_buf  <= '0;
                    byte_idx <= '0;
                    done_r   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rle_decoder.sv
// Directed bench for rle_decoder: behavioural dpsram, expected-write queue checked by a monitor, decode-result checks.
`timescale 1ns/1ps
module tb_rle_decoder;
    localparam int ADDR_W = 16;
    localparam int W      = 48;

    logic              clk;
    logic              nreset;
    logic              start;
    logic [31:0]       rle_addr, rle_size, message_addr;
    logic [31:0]       message_size;
    logic              done;
    logic              port_A_clk;
    logic [ADDR_W-1:0] port_A_addr;
    logic              port_A_we;
    logic [31:0]       port_A_data_in;
    logic [31:0]       port_A_data_out;
    logic [2:0]        state_dbg;
`ifdef RLD_BOUND_CHECK_EN
    logic [31:0]       message_limit;
    logic              overflow;
`endif

    rle_decoder #(.ADDR_W(ADDR_W)) dut (
        .clk            (clk),
        .nreset         (nreset),
        .start          (start),
        .rle_addr       (rle_addr),
        .rle_size       (rle_size),
        .message_addr   (message_addr),
`ifdef RLD_BOUND_CHECK_EN
        .message_limit  (message_limit),
        .overflow       (overflow),
`endif
        .message_size   (message_size),
        .done           (done),
        .port_A_clk     (port_A_clk),
        .port_A_addr    (port_A_addr),
        .port_A_we      (port_A_we),
        .port_A_data_in (port_A_data_in),
        .port_A_data_out(port_A_data_out),
        .state_dbg      (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // dpsram model with a bench-side load port
    logic [31:0] mem [0:1023];
    logic        ld_en;
    logic [9:0]  ld_idx;
    logic [31:0] ld_data;

    always @(posedge clk) begin
        if (ld_en)
            mem[ld_idx] <= ld_data;
        else if (port_A_we)
            mem[port_A_addr[11:2]] <= port_A_data_in;
        port_A_data_out <= mem[port_A_addr[11:2]];
    end

    // scoreboard
    logic [W-1:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (nreset && port_A_we) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected no write", port_A_addr, port_A_data_in);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                check("write_addr", 64'(port_A_addr), 64'(e[47:32]));
                check("write_data", 64'(port_A_data_in), 64'(e[31:0]));
            end
        end
    end

    // driver tasks
    task automatic load_word(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_idx  = addr[11:2];
        ld_data = data;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    task automatic push_write(input logic [15:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic pulse_start(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma);
        @(negedge clk);
        rle_addr     = ra;
        rle_size     = rs;
        message_addr = ma;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
    endtask

    task automatic run_decode(input string name, input logic [31:0] ra, input logic [31:0] rs,
                              input logic [31:0] ma, input logic [31:0] exp_size, output int cyc);
        pulse_start(ra, rs, ma);
        check({name, "_done_dropped"}, 64'(done), 64'd0);
        cyc = 1;
        while (!done && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_message_size"}, 64'(message_size), 64'(exp_size));
        check({name, "_writes_drained"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        nreset       = 1'b0;
        start        = 1'b0;
        rle_addr     = '0;
        rle_size     = '0;
        message_addr = '0;
        ld_en        = 1'b0;
        ld_idx       = '0;
        ld_data      = '0;
`ifdef RLD_BOUND_CHECK_EN
        message_limit = 32'hFFFF_FFFF;
`endif
        #1;
        check("rst_done", 64'(done), 64'd0);
        check("rst_message_size", 64'(message_size), 64'd0);
        check("rst_we", 64'(port_A_we), 64'd0);
        check("rst_addr", 64'(port_A_addr), 64'd0);
        check("rst_data_in", 64'(port_A_data_in), 64'd0);
        check("rst_state", 64'(state_dbg), 64'd0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        // (A x3),(B x2)
        load_word(32'h100, 32'h4202_4103);
        push_write(16'h0200, 32'h4241_4141);
        push_write(16'h0204, 32'h0000_0042);
        run_decode("two_runs", 32'h100, 32'd4, 32'h200, 32'd5, cyc);
`ifdef RLD_BOUND_CHECK_EN
        check("two_runs_no_overflow", 64'(overflow), 64'd0);
`endif

        // single pair 0x7E x8; pair1 of the word must be ignored
        load_word(32'h110, 32'hFFFF_7E08);
        push_write(16'h0300, 32'h7E7E_7E7E);
        push_write(16'h0304, 32'h7E7E_7E7E);
        run_decode("single_pair", 32'h110, 32'd2, 32'h300, 32'd8, cyc);

        // zero-count pair between runs
        load_word(32'h120, 32'h3300_1102);
        load_word(32'h124, 32'h5501_4403);
        push_write(16'h0400, 32'h4444_1111);
        push_write(16'h0404, 32'h0000_5544);
        run_decode("zero_count", 32'h120, 32'd8, 32'h400, 32'd6, cyc);

        // odd pair count, output ends exactly on a word boundary
        load_word(32'h130, 32'h0A01_0902);
        load_word(32'h134, 32'hFF05_0B01);
        push_write(16'h0500, 32'h0B0A_0909);
        run_decode("odd_pairs", 32'h130, 32'd6, 32'h500, 32'd4, cyc);

        // output address wraps modulo 2^ADDR_W
        load_word(32'h140, 32'h0000_5108);
        push_write(16'hFFFC, 32'h5151_5151);
        push_write(16'h0000, 32'h5151_5151);
        run_decode("addr_wrap", 32'h140, 32'd2, 32'h0001_FFFC, 32'd8, cyc);

        // empty stream
        run_decode("empty", 32'h100, 32'd0, 32'h600, 32'd0, cyc);
        check("empty_latency_ok", 64'(cyc <= 3), 64'd1);

        // reset asserted in EXPAND aborts with no write
        pulse_start(32'h110, 32'd2, 32'h700);
        cyc = 0;
        while (state_dbg != 3'd3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("abort_reached_expand", 64'(state_dbg), 64'd3);
        #2;
        nreset = 1'b0;
        #1;
        check("abort_we", 64'(port_A_we), 64'd0);
        check("abort_done", 64'(done), 64'd0);
        check("abort_state", 64'(state_dbg), 64'd0);
        check("abort_message_size", 64'(message_size), 64'd0);
        @(negedge clk);
        nreset = 1'b1;
        push_write(16'h0800, 32'h4241_4141);
        push_write(16'h0804, 32'h0000_0042);
        run_decode("after_abort", 32'h100, 32'd4, 32'h800, 32'd5, cyc);

`ifdef RLD_BOUND_CHECK_EN
        message_limit = 32'd3;
        load_word(32'h150, 32'h0000_1105);
        push_write(16'h0900, 32'h0011_1111);
        run_decode("bounded", 32'h150, 32'd2, 32'h900, 32'd3, cyc);
        check("bounded_overflow", 64'(overflow), 64'd1);
`endif

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
